// File: rtl/alu_issue_sel_pkg.sv
// Shared core parameters for the ALU reservation station and its issue select.
// Holds the RS geometry defaults (entry count, index width, spectag width), the
// RS-entry payload widths, and the action encoding used by the issue register.
package alu_issue_sel_pkg;

  // ALU reservation-station geometry.
  localparam int RS_ALU_ENT_NUM   = 16;
  localparam int RS_ALU_ENT_SEL   = 4;
  localparam int CORE_SPECTAG_LEN = 5;

  // RS-entry payload widths.
  localparam int CORE_DATA_LEN    = 32;
  localparam int CORE_RRF_SEL     = 6;
  localparam int CORE_ALU_OP_LEN  = 4;

  // What the issue register does at the next edge.
  typedef enum logic [1:0] {
    ISS_HOLD    = 2'd0,  // keep contents (idle or stalled)
    ISS_CAPTURE = 2'd1,  // load the selected entry
    ISS_DROP    = 2'd2   // consumed by the ALU or killed, nothing to replace it
  } iss_action_e;

endpackage : alu_issue_sel_pkg

// File: rtl/alu_issue_sel_age.sv
// age_matrix_sel: age matrix over the ALU RS entries plus oldest-candidate pick.
//   clk, rst          clock, asynchronous active-low reset
//   alloc_we_i        an entry is being written by dispatch this cycle
//   alloc_addr_i      index of that entry
//   ent_busy_i        per-entry busy flags (entries already holding an op)
//   cand_i            per-entry candidate flags (ready and not killed)
//   sel_onehot_o      oldest candidate, one-hot (zero when no candidate)
//   sel_valid_o       at least one candidate exists
//   sel_addr_o        binary index of sel_onehot_o
module age_matrix_sel
  import alu_issue_sel_pkg::*;
#(
  parameter int ENT_NUM = RS_ALU_ENT_NUM,
  parameter int ENT_SEL = RS_ALU_ENT_SEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_we_i,
  input  logic [ENT_SEL-1:0] alloc_addr_i,
  input  logic [ENT_NUM-1:0] ent_busy_i,
  input  logic [ENT_NUM-1:0] cand_i,
  output logic [ENT_NUM-1:0] sel_onehot_o,
  output logic               sel_valid_o,
  output logic [ENT_SEL-1:0] sel_addr_o
);

  // older_q[i][j] = 1: entry i was allocated before entry j.
  logic [ENT_NUM-1:0][ENT_NUM-1:0] older_q, older_d;
  // older_col[i][j] = older_q[j][i] with the diagonal forced to 0.
  logic [ENT_NUM-1:0][ENT_NUM-1:0] older_col;

  // A new entry is younger than everything currently busy and older than
  // nothing: clear its row, set its column for the busy entries.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    older_d = older_q;
    if (alloc_we_i) begin
      for (int i = 0; i < ENT_NUM; i++) begin
        older_d[alloc_addr_i][i] = 1'b0;
        older_d[i][alloc_addr_i] = ent_busy_i[i] && (alloc_addr_i != ENT_SEL'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the matrix is an ordinary flop array, so it is reset like any other
    // state; reset must leave no stale ordering behind.
    if (!rst) begin
      older_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      older_q <= older_d;
    end
  end

  // Entry i wins when no other candidate is older than it. Busy entries form a
  // total order, so among ready (hence busy) entries exactly one wins.
  for (genvar gi = 0; gi < ENT_NUM; gi++) begin : g_pick
    for (genvar gj = 0; gj < ENT_NUM; gj++) begin : g_col
      if (gi == gj) begin : g_diag
        assign older_col[gi][gj] = 1'b0;
      end else begin : g_off
        assign older_col[gi][gj] = older_q[gj][gi];
      end
    end
    assign sel_onehot_o[gi] = cand_i[gi] & ~|(cand_i & older_col[gi]);
  end

  assign sel_valid_o = |cand_i;

  // One-hot to binary as an OR of indices: no priority chain needed.
  always_comb begin
    sel_addr_o = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (sel_onehot_o[i]) sel_addr_o = sel_addr_o | ENT_SEL'(i);
    end
  end

endmodule : age_matrix_sel

// File: rtl/alu_issue_sel.sv
// alu_issue_sel: picks the oldest ready, non-killed ALU RS entry and loads it
// into a single issue register feeding the ALU.
//   clk, rst        clock, asynchronous active-low reset
//   alloc_we/addr   dispatch write of an RS entry (drives the age matrix)
//   ent_busy        per-entry busy flags
//   ent_ready       per-entry ready flags
//   ent_spectag     packed per-entry spectags, entry i at [i*SPECTAG_LEN +: SPECTAG_LEN]
//   prmiss          branch mispredict, specfixtag is the kill mask
//   alu_stall       ALU cannot take the issue register this cycle
//   clear_busy      one-hot, frees the entry captured this cycle
//   iss_valid/addr/spectag  issue register contents
module alu_issue_sel
  import alu_issue_sel_pkg::*;
#(
  parameter int ENT_NUM     = RS_ALU_ENT_NUM,
  parameter int ENT_SEL     = RS_ALU_ENT_SEL,
  parameter int SPECTAG_LEN = CORE_SPECTAG_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_we,
  input  logic [ENT_SEL-1:0]             alloc_addr,
  input  logic [ENT_NUM-1:0]             ent_busy,
  input  logic [ENT_NUM-1:0]             ent_ready,
  input  logic [ENT_NUM*SPECTAG_LEN-1:0] ent_spectag,
  input  logic                           prmiss,
  input  logic [SPECTAG_LEN-1:0]         specfixtag,
  input  logic                           alu_stall,
  output logic [ENT_NUM-1:0]             clear_busy,
  output logic                           iss_valid,
  output logic [ENT_SEL-1:0]             iss_addr,
  output logic [SPECTAG_LEN-1:0]         iss_spectag
);

  logic [ENT_NUM-1:0]     kill;
  logic [ENT_NUM-1:0]     cand;
  logic [ENT_NUM-1:0]     sel_onehot;
  logic                   sel_valid;
  logic [ENT_SEL-1:0]     sel_addr;
  logic [SPECTAG_LEN-1:0] sel_spectag;
  logic                   iss_kill;
  iss_action_e            action;

  logic                   iss_valid_q, iss_valid_d;
  logic [ENT_SEL-1:0]     iss_addr_q, iss_addr_d;
  logic [SPECTAG_LEN-1:0] iss_spectag_q, iss_spectag_d;

  // Kill check per entry, and spectag of the selected entry (one-hot mux).
  always_comb begin
    kill        = '0;
    sel_spectag = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      kill[i]     = prmiss & |(ent_spectag[i*SPECTAG_LEN +: SPECTAG_LEN] & specfixtag);
      sel_spectag = sel_spectag |
                    (ent_spectag[i*SPECTAG_LEN +: SPECTAG_LEN] & {SPECTAG_LEN{sel_onehot[i]}});
    end
  end

  assign cand = ent_ready & ~kill;

  age_matrix_sel #(
    .ENT_NUM (ENT_NUM),
    .ENT_SEL (ENT_SEL)
  ) u_age (
    .clk          (clk),
    .rst          (rst),
    .alloc_we_i   (alloc_we),
    .alloc_addr_i (alloc_addr),
    .ent_busy_i   (ent_busy),
    .cand_i       (cand),
    .sel_onehot_o (sel_onehot),
    .sel_valid_o  (sel_valid),
    .sel_addr_o   (sel_addr)
  );

  // A killed issue register is empty for this edge even when stalled, so a
  // surviving candidate may replace it.
  assign iss_kill = prmiss & |(iss_spectag_q & specfixtag);

  always_comb begin
    action        = ISS_HOLD;
    iss_valid_d   = iss_valid_q;
    iss_addr_d    = iss_addr_q;
    iss_spectag_d = iss_spectag_q;
    if (sel_valid && (!iss_valid_q || !alu_stall || iss_kill)) begin
      action        = ISS_CAPTURE;
      iss_valid_d   = 1'b1;
      iss_addr_d    = sel_addr;
      iss_spectag_d = sel_spectag;
    end else if (iss_valid_q && (iss_kill || !alu_stall)) begin
      action      = ISS_DROP;
      iss_valid_d = 1'b0;
    end
  end

  // Gated by reset so nothing is freed while the block is held in reset.
  assign clear_busy = (rst && (action == ISS_CAPTURE)) ? sel_onehot : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_q   <= 1'b0;
      iss_addr_q    <= '0;
      iss_spectag_q <= '0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      iss_addr_q    <= iss_addr_d;
      iss_spectag_q <= iss_spectag_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_addr    = iss_addr_q;
  assign iss_spectag = iss_spectag_q;

endmodule : alu_issue_sel
